// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase scheduler.
// Optional build macro: TRAFFIC_ALL_RED_EN adds an all-red clearance phase
// after each yellow and widens the phase encoding to 3 bits.
package traffic_pkg;

    localparam int unsigned REMAIN_W = 6;
    localparam int unsigned GREEN_W  = 6;
    localparam int unsigned YELLOW_W = 4;
    localparam int unsigned BCD_W    = 4;
    localparam int unsigned LIGHT_W  = 2;

`ifdef TRAFFIC_ALL_RED_EN
    localparam int unsigned PHASE_W = 3;
`else
    localparam int unsigned PHASE_W = 2;
`endif

    localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = LIGHT_W'(1);
    localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = LIGHT_W'(2);
    localparam logic [LIGHT_W-1:0] LIGHT_RED    = LIGHT_W'(3);

    localparam logic [REMAIN_W-1:0] RESET_GREEN    = REMAIN_W'(20);
    localparam logic [REMAIN_W-1:0] PED_MIN_REMAIN = REMAIN_W'(5);

    // Phase encoding, also driven out on the phase port
    typedef enum logic [PHASE_W-1:0] {
        ST_G1,
        ST_Y1,
        ST_G2,
        ST_Y2
`ifdef TRAFFIC_ALL_RED_EN
        ,
        ST_AR1,
        ST_AR2
`endif
    } state_e;

    // Lamp pair driven to the two roads
    typedef struct packed {
        logic [LIGHT_W-1:0] light1;
        logic [LIGHT_W-1:0] light2;
    } lamps_t;

    // Successor phase in the fixed rotation
    function automatic state_e next_phase(input state_e s);
        state_e n;
        case (s)
            ST_G1:   n = ST_Y1;
            ST_G2:   n = ST_Y2;
`ifdef TRAFFIC_ALL_RED_EN
            ST_Y1:   n = ST_AR1;
            ST_AR1:  n = ST_G2;
            ST_Y2:   n = ST_AR2;
            ST_AR2:  n = ST_G1;
`else
            ST_Y1:   n = ST_G2;
            ST_Y2:   n = ST_G1;
`endif
            default: n = ST_G1;
        endcase
        return n;
    endfunction

    // Lamp codes shown in a given phase
    function automatic lamps_t lamps_of(input state_e s);
        lamps_t l;
        case (s)
            ST_G1:   l = '{light1: LIGHT_GREEN,  light2: LIGHT_RED};
            ST_Y1:   l = '{light1: LIGHT_YELLOW, light2: LIGHT_RED};
            ST_G2:   l = '{light1: LIGHT_RED,    light2: LIGHT_GREEN};
            ST_Y2:   l = '{light1: LIGHT_RED,    light2: LIGHT_YELLOW};
            default: l = '{light1: LIGHT_RED,    light2: LIGHT_RED};
        endcase
        return l;
    endfunction

    // A configured duration of zero still lasts one second
    function automatic logic [REMAIN_W-1:0] clamp_dur(input logic [REMAIN_W-1:0] d);
        return (d == '0) ? REMAIN_W'(1) : d;
    endfunction

endpackage

// File: rtl/traffic_bcd_split.sv
// Splits a 6-bit binary value (0..63) into tens and ones BCD digits.
module traffic_bcd_split
    import traffic_pkg::*;
(
    input  logic [REMAIN_W-1:0] bin_i,
    output logic [BCD_W-1:0]    tens_o,
    output logic [BCD_W-1:0]    ones_o
);

    logic [REMAIN_W-1:0] base;

    // Tens digit by range compare; base is the value that digit accounts for
    always_comb begin
        tens_o = '0;
        base   = '0;
        if (bin_i >= REMAIN_W'(60)) begin
            tens_o = BCD_W'(6);
            base   = REMAIN_W'(60);
        end else if (bin_i >= REMAIN_W'(50)) begin
            tens_o = BCD_W'(5);
            base   = REMAIN_W'(50);
        end else if (bin_i >= REMAIN_W'(40)) begin
            tens_o = BCD_W'(4);
            base   = REMAIN_W'(40);
        end else if (bin_i >= REMAIN_W'(30)) begin
            tens_o = BCD_W'(3);
            base   = REMAIN_W'(30);
        end else if (bin_i >= REMAIN_W'(20)) begin
            tens_o = BCD_W'(2);
            base   = REMAIN_W'(20);
        end else if (bin_i >= REMAIN_W'(10)) begin
            tens_o = BCD_W'(1);
            base   = REMAIN_W'(10);
        end
    end

    assign ones_o = BCD_W'(bin_i - base);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road traffic light phase scheduler with pedestrian green truncation.
// Optional build macro: TRAFFIC_ALL_RED_EN (all-red phase after each yellow).
module traffic_phase_scheduler
    import traffic_pkg::*;
(
    input  logic                clk2,
    input  logic                reset_n,
    input  logic                tick,
    input  logic [GREEN_W-1:0]  cfg_green1,
    input  logic [GREEN_W-1:0]  cfg_green2,
    input  logic [YELLOW_W-1:0] cfg_yellow,
    input  logic                ped_req1,
    input  logic                ped_req2,
    output logic                ped_ack1,
    output logic                ped_ack2,
    output logic [LIGHT_W-1:0]  light1,
    output logic [LIGHT_W-1:0]  light2,
    output logic [REMAIN_W-1:0] remain,
    output logic [BCD_W-1:0]    remain_tens,
    output logic [BCD_W-1:0]    remain_ones,
    output logic [PHASE_W-1:0]  phase
);

    state_e              state_q, state_d;
    logic [REMAIN_W-1:0] remain_q, remain_d;
    logic                pend1_q, pend1_d;
    logic                pend2_q, pend2_d;
    logic                ack1_q, ack1_d;
    logic                ack2_q, ack2_d;
    logic                first_q;
    lamps_t              lamps_q, lamps_d;
    logic [BCD_W-1:0]    tens_q, tens_d;
    logic [BCD_W-1:0]    ones_q, ones_d;
    logic [REMAIN_W-1:0] entry_dur_c;

    logic tick_ok_c;
    logic req1_c, req2_c;
    logic svc1_c, svc2_c;
    logic trunc_c;

    // The first edge after reset release never counts a tick
    assign tick_ok_c = tick & ~first_q;
    // A request raised this cycle is serviceable on this same edge
    assign req1_c    = pend1_q | ped_req1;
    assign req2_c    = pend2_q | ped_req2;
    assign svc1_c    = (state_q == ST_G1) & req1_c;
    assign svc2_c    = (state_q == ST_G2) & req2_c;
    assign trunc_c   = (svc1_c | svc2_c) & (remain_q > PED_MIN_REMAIN);

    // Duration loaded on entry to the phase that follows the current one
    always_comb begin
        entry_dur_c = REMAIN_W'(1);
        case (next_phase(state_q))
            ST_G1:   entry_dur_c = clamp_dur(cfg_green1);
            ST_G2:   entry_dur_c = clamp_dur(cfg_green2);
            ST_Y1,
            ST_Y2:   entry_dur_c = clamp_dur(REMAIN_W'(cfg_yellow));
            default: entry_dur_c = REMAIN_W'(1);
        endcase
    end

    // Phase sequencing, countdown, pedestrian truncation and output staging
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        pend1_d  = req1_c & ~svc1_c;
        pend2_d  = req2_c & ~svc2_c;
        ack1_d   = svc1_c;
        ack2_d   = svc2_c;

        if (trunc_c) begin
            // Truncation wins over a coincident tick; the tick is dropped
            remain_d = PED_MIN_REMAIN;
        end else if (tick_ok_c) begin
            if (remain_q > REMAIN_W'(1)) begin
                remain_d = REMAIN_W'(remain_q - REMAIN_W'(1));
            end else begin
                state_d  = next_phase(state_q);
                remain_d = entry_dur_c;
            end
        end

        lamps_d = lamps_of(state_d);
    end

    // BCD digits derived from the next remain value so they track it exactly
    traffic_bcd_split u_bcd (
        .bin_i  (remain_d),
        .tens_o (tens_d),
        .ones_o (ones_d)
    );

    // State and registered outputs
    always_ff @(posedge clk2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_G1;
            remain_q <= RESET_GREEN;
            pend1_q  <= 1'b0;
            pend2_q  <= 1'b0;
            ack1_q   <= 1'b0;
            ack2_q   <= 1'b0;
            first_q  <= 1'b1;
            lamps_q  <= '{light1: LIGHT_GREEN, light2: LIGHT_RED};
            tens_q   <= BCD_W'(2);
            ones_q   <= BCD_W'(0);
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            pend1_q  <= pend1_d;
            pend2_q  <= pend2_d;
            ack1_q   <= ack1_d;
            ack2_q   <= ack2_d;
            first_q  <= 1'b0;
            lamps_q  <= lamps_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
        end
    end

    assign phase       = state_q;
    assign remain      = remain_q;
    assign remain_tens = tens_q;
    assign remain_ones = ones_q;
    assign light1      = lamps_q.light1;
    assign light2      = lamps_q.light2;
    assign ped_ack1    = ack1_q;
    assign ped_ack2    = ack2_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios plus
// randomized traffic against a table-driven reference model.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    logic                clk2 = 1'b0;
    logic                reset_n = 1'b0;
    logic                tick = 1'b0;
    logic [GREEN_W-1:0]  cfg_green1 = 6'd10;
    logic [GREEN_W-1:0]  cfg_green2 = 6'd10;
    logic [YELLOW_W-1:0] cfg_yellow = 4'd3;
    logic                ped_req1 = 1'b0;
    logic                ped_req2 = 1'b0;
    logic                ped_ack1, ped_ack2;
    logic [LIGHT_W-1:0]  light1, light2;
    logic [REMAIN_W-1:0] remain;
    logic [BCD_W-1:0]    remain_tens, remain_ones;
    logic [PHASE_W-1:0]  phase;

    traffic_phase_scheduler dut (
        .clk2        (clk2),
        .reset_n     (reset_n),
        .tick        (tick),
        .cfg_green1  (cfg_green1),
        .cfg_green2  (cfg_green2),
        .cfg_yellow  (cfg_yellow),
        .ped_req1    (ped_req1),
        .ped_req2    (ped_req2),
        .ped_ack1    (ped_ack1),
        .ped_ack2    (ped_ack2),
        .light1      (light1),
        .light2      (light2),
        .remain      (remain),
        .remain_tens (remain_tens),
        .remain_ones (remain_ones),
        .phase       (phase)
    );

    always #5 clk2 = ~clk2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: kinds 0=G1 1=Y1 2=G2 3=Y2 4=all-red
`ifdef TRAFFIC_ALL_RED_EN
    localparam int SEQ_LEN = 6;
    int seq_kind[SEQ_LEN]  = '{0, 1, 4, 2, 3, 4};
    int seq_phase[SEQ_LEN] = '{int'(ST_G1), int'(ST_Y1), int'(ST_AR1),
                               int'(ST_G2), int'(ST_Y2), int'(ST_AR2)};
`else
    localparam int SEQ_LEN = 4;
    int seq_kind[SEQ_LEN]  = '{0, 1, 2, 3};
    int seq_phase[SEQ_LEN] = '{int'(ST_G1), int'(ST_Y1), int'(ST_G2), int'(ST_Y2)};
`endif
    int lamp1_of[5]   = '{1, 2, 3, 3, 3};
    int lamp2_of[5]   = '{3, 3, 1, 2, 3};
    int kind_phase[4] = '{int'(ST_G1), int'(ST_Y1), int'(ST_G2), int'(ST_Y2)};

    int m_idx, m_rem;
    bit m_p1, m_p2, m_ack1, m_ack2, m_first;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int at_least_one(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int dur_of(input int kind);
        case (kind)
            0:       return at_least_one(int'(cfg_green1));
            2:       return at_least_one(int'(cfg_green2));
            1, 3:    return at_least_one(int'(cfg_yellow));
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_idx = 0; m_rem = 20; m_p1 = 0; m_p2 = 0;
        m_ack1 = 0; m_ack2 = 0; m_first = 1;
    endtask

    task automatic model_step(input bit t, input bit r1, input bit r2);
        bit t_eff, q1, q2, s1, s2;
        t_eff   = t && !m_first;
        m_first = 0;
        q1 = m_p1 || r1;
        q2 = m_p2 || r2;
        s1 = (seq_kind[m_idx] == 0) && q1;
        s2 = (seq_kind[m_idx] == 2) && q2;
        m_ack1 = s1; m_ack2 = s2;
        m_p1 = q1 && !s1;
        m_p2 = q2 && !s2;
        if ((s1 || s2) && m_rem > 5) begin
            m_rem = 5;
        end else if (t_eff) begin
            if (m_rem > 1) m_rem = m_rem - 1;
            else begin
                m_idx = (m_idx + 1) % SEQ_LEN;
                m_rem = dur_of(seq_kind[m_idx]);
            end
        end
    endtask

    task automatic check_all(input string tag);
        int k;
        k = seq_kind[m_idx];
        chk({tag, ".light1"}, 32'(light1), lamp1_of[k]);
        chk({tag, ".light2"}, 32'(light2), lamp2_of[k]);
        chk({tag, ".phase"},  32'(phase), seq_phase[m_idx]);
        chk({tag, ".remain"}, 32'(remain), m_rem);
        chk({tag, ".tens"},   32'(remain_tens), m_rem / 10);
        chk({tag, ".ones"},   32'(remain_ones), m_rem % 10);
        chk({tag, ".ack1"},   32'(ped_ack1), 32'(m_ack1));
        chk({tag, ".ack2"},   32'(ped_ack2), 32'(m_ack2));
    endtask

    task automatic step(input bit t, input bit r1, input bit r2);
        @(negedge clk2);
        tick = t; ped_req1 = r1; ped_req2 = r2;
        @(posedge clk2);
        model_step(t, r1, r2);
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk2);
        reset_n = 1'b0; tick = 1'b0; ped_req1 = 1'b0; ped_req2 = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(posedge clk2);
        #1;
        reset_n = 1'b1;
    endtask

    // Tick until the model reaches the given kind, bounded by a cycle budget
    task automatic go_to(input int kind, input int max_cyc);
        int n;
        n = 0;
        while (seq_kind[m_idx] != kind && n < max_cyc) begin
            step(1, 0, 0);
            n++;
        end
        chk("goto.phase", 32'(phase), kind_phase[kind]);
    endtask

    initial begin
        // Reset values and the ignored first tick
        cfg_green1 = 6'd10; cfg_green2 = 6'd4; cfg_yellow = 4'd3;
        do_reset();
        chk("rst.remain", 32'(remain), 20);
        chk("rst.tens",   32'(remain_tens), 2);
        chk("rst.ones",   32'(remain_ones), 0);
        step(1, 0, 0);
        chk("first_tick_ignored", 32'(remain), 20);

        // Full rotation, then a 10 s green ending in Y1 on the 10th tick
        go_to(1, 40);
        go_to(0, 40);
        chk("g1_entry_len", 32'(remain), 10);
        repeat (9) step(1, 0, 0);
        chk("g1_last_sec", 32'(remain), 1);
        step(1, 0, 0);
        chk("y1_entry.phase",  32'(phase), int'(ST_Y1));
        chk("y1_entry.remain", 32'(remain), 3);
        chk("y1_entry.light1", 32'(light1), 2);

        // Truncation at 15 and no-op service at 4
        do_reset();
        step(0, 0, 0);
        repeat (5) step(1, 0, 0);
        chk("ped1.before", 32'(remain), 15);
        step(0, 1, 0);
        chk("ped1.trunc", 32'(remain), 5);
        chk("ped1.ack", 32'(ped_ack1), 1);
        step(0, 0, 0);
        chk("ped1.ack_once", 32'(ped_ack1), 0);
        step(1, 0, 0);
        step(0, 1, 0);
        chk("ped1.small_remain", 32'(remain), 4);
        chk("ped1.small_ack", 32'(ped_ack1), 1);
        step(0, 0, 0);
        chk("ped1.small_ack_once", 32'(ped_ack1), 0);

        // Road 2 request held through G1, serviced one cycle after G2 entry
        cfg_green2 = 6'd30; cfg_yellow = 4'd3;
        do_reset();
        step(0, 0, 0);
        step(0, 0, 1);
        chk("ped2.no_ack_in_g1", 32'(ped_ack2), 0);
        go_to(2, 40);
        chk("ped2.g2_entry", 32'(remain), 30);
        chk("ped2.g2_entry_ack", 32'(ped_ack2), 0);
        step(0, 0, 0);
        chk("ped2.trunc", 32'(remain), 5);
        chk("ped2.ack", 32'(ped_ack2), 1);

        // Truncation beats a coincident tick
        do_reset();
        step(0, 0, 0);
        repeat (8) step(1, 0, 0);
        chk("prio.before", 32'(remain), 12);
        step(1, 1, 0);
        chk("prio.trunc_wins", 32'(remain), 5);

        // Zero yellow lasts exactly one tick
        cfg_yellow = 4'd0;
        do_reset();
        step(0, 0, 0);
        go_to(1, 40);
        chk("y0.len", 32'(remain), 1);
        step(1, 0, 0);
`ifdef TRAFFIC_ALL_RED_EN
        chk("y0.next", 32'(phase), int'(ST_AR1));
        chk("ar.len", 32'(remain), 1);
        step(1, 0, 0);
        chk("ar.next", 32'(phase), int'(ST_G2));
`else
        chk("y0.next", 32'(phase), int'(ST_G2));
`endif

        // Reset mid-G2 with road 1 pending
        cfg_green1 = 6'd3; cfg_yellow = 4'd2; cfg_green2 = 6'd20;
        do_reset();
        step(0, 0, 0);
        go_to(2, 40);
        step(1, 0, 0);
        step(0, 1, 0);
        chk("rst2.pending_no_ack", 32'(ped_ack1), 0);
        do_reset();
        chk("rst2.phase",  32'(phase), int'(ST_G1));
        chk("rst2.remain", 32'(remain), 20);
        chk("rst2.tens",   32'(remain_tens), 2);
        chk("rst2.ones",   32'(remain_ones), 0);
        chk("rst2.light1", 32'(light1), 1);
        chk("rst2.light2", 32'(light2), 3);
        repeat (6) begin
            step(0, 0, 0);
            chk("rst2.no_ack", 32'(ped_ack1), 0);
        end

        // Randomized traffic, including mid-phase cfg changes and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                cfg_green1 = 6'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 63 : 12));
                cfg_green2 = 6'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 63 : 12));
                cfg_yellow = 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 4));
            end
            if ($urandom_range(0, 600) == 0) do_reset();
            step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 SHALL have port clk2, input, 1 bit: single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port tick, input, 1 bit: one-cycle 1 Hz enable pulse, synchronous to clk2.
REQ-004 SHALL have ports cfg_green1 and cfg_green2, input, 6 bits each: green duration in seconds for road 1 and road 2.
REQ-005 SHALL have port cfg_yellow, input, 4 bits: yellow duration in seconds, shared by both roads.
REQ-006 SHALL have ports ped_req1 and ped_req2, input, 1 bit each: level request to shorten road 1 or road 2 green.
REQ-007 SHALL have ports ped_ack1 and ped_ack2, output, 1 bit each: one-cycle pulse when the matching request is serviced.
REQ-008 SHALL have ports light1 and light2, output, 2 bits each: lamp code, 1=green, 2=yellow, 3=red.
REQ-009 SHALL have port remain, output, 6 bits: seconds left in the current phase, binary.
REQ-010 SHALL have ports remain_tens and remain_ones, output, 4 bits each: BCD split of remain.
REQ-011 SHALL have port phase, output, 2 bits: current state encoding.

Function
REQ-012 SHALL implement the state cycle G1 -> Y1 -> G2 -> Y2 -> G1.
- G1: light1=1, light2=3.
- Y1: light1=2, light2=3.
- G2: light1=3, light2=1.
- Y2: light1=3, light2=2.
REQ-013 SHALL act on a tick only; on a tick with remain>1, remain decrements by 1; on a tick with remain==1, the block moves to the next state and loads that state's duration in the same cycle.
REQ-014 SHALL sample the cfg inputs only at state entry; changes to cfg mid-phase SHALL have no effect on the current phase.
REQ-015 SHALL clamp a configured duration of 0 to 1; remain SHALL therefore never equal 0 after reset.
REQ-016 SHALL set a sticky pending bit on any cycle where ped_reqN=1; the pending bit SHALL clear only when serviced or on reset.
REQ-017 SHALL service pending1 in G1 on the next clk2 edge:
- if remain>5, remain is set to 5;
- otherwise remain is unchanged;
- in both cases pending1 clears and ped_ack1 pulses for one cycle.
REQ-018 SHALL service pending2 in G2 by the same rule as REQ-017.
REQ-019 SHALL hold a request raised outside its green state pending until that green state is entered.
REQ-020 SHALL, when a truncation and a tick occur in the same cycle, give truncation priority: remain becomes 5 and the tick is discarded.
REQ-021 SHALL drive light1, light2, phase, remain, remain_tens, remain_ones and ped_ack* as registered outputs, changing one cycle after the causing edge.

Reset
REQ-022 SHALL, on reset_n=0, immediately and from any state (including mid-phase or with a request pending):
- enter G1 with light1=1, light2=3, phase=G1;
- set remain=20, remain_tens=2, remain_ones=0;
- clear pending1 and pending2 and drive ped_ack1=ped_ack2=0.
REQ-023 SHALL ignore tick on the first clk2 edge after reset_n deasserts.

Configuration
REQ-024 SHALL, with TRAFFIC_ALL_RED_EN defined, insert state AR (light1=light2=3, duration 1 s) after both Y1 and Y2; phase SHALL then be 3 bits wide.
REQ-025 SHALL, with TRAFFIC_ALL_RED_EN undefined, have no AR state and a 2-bit phase; the cycle SHALL be exactly as REQ-012.

Structure
REQ-026 SHALL place the following in the shared package traffic_pkg:
- lamp codes LIGHT_GREEN, LIGHT_YELLOW, LIGHT_RED;
- the state enum;
- RESET_GREEN=20 and PED_MIN_REMAIN=5.
REQ-027 SHALL produce remain_tens and remain_ones through the sub-module traffic_bcd_split (6-bit binary to two BCD digits, range 0..63), registered at the parent.

Verification
REQ-028 SHALL verify: reset, cfg_green1=10, cfg_yellow=3, 10 ticks -> Y1 entered on the 10th tick with remain=3, light1=2.
REQ-029 SHALL verify: ped_req1 pulse in G1 at remain=15 -> remain=5 on the next cycle, one ped_ack1 pulse; at remain=4 -> remain stays 4, ack still pulses.
REQ-030 SHALL verify: ped_req2 during G1 -> no ack until G2 entry; at G2 entry with cfg_green2=30, remain=5 one cycle later.
REQ-031 SHALL verify: tick and truncation in the same cycle at remain=12 -> remain=5, not 4.
REQ-032 SHALL verify: cfg_yellow=0 -> Y1 lasts exactly 1 tick; with TRAFFIC_ALL_RED_EN, Y1 -> AR for 1 tick -> G2.
REQ-033 SHALL verify: reset_n asserted mid-G2 with pending1 set -> G1, remain=20, tens/ones=2/0, no ack afterwards.
